// File: rtl/crypt_sequencer.sv
// Hardware sequencer for the Program #1 encryption job: reads config and plaintext
// from data memory, writes LFSR-masked, parity-tagged ciphertext back, then raises Ack.
//
// state   | meaning
// IDLE    | waiting for Start low
// LD_PRE  | fetch pre_length
// LD_TAP  | fetch pattern select, latch LFSR tap mask
// LD_SEED | fetch LFSR seed, clear index
// ENC_RD  | fetch plaintext byte (or substitute a space)
// ENC_WR  | write ciphertext byte, step LFSR and index
// DONE    | Ack held until Start returns high
module crypt_sequencer #(
   parameter int MSG_BASE = 0,
   parameter int CFG_BASE = 61,
   parameter int OUT_BASE = 64,
   parameter int PAD_LEN  = 64
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] MemAddr,
   input  logic [7:0] MemRdData,
   output logic       MemWrEn,
   output logic [7:0] MemWrData
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_PRE  = 3'd1,
      LD_TAP  = 3'd2,
      LD_SEED = 3'd3,
      ENC_RD  = 3'd4,
      ENC_WR  = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t     state, state_nxt;
   logic [6:0] idx;
   logic [6:0] lfsr;
   logic [7:0] pre_len;
   logic [6:0] tap;
   logic [7:0] ptxt;

   logic [7:0] msg_ofs;
   logic       in_msg;
   logic [6:0] cipher;
   logic [6:0] tap_sel;
   logic [6:0] seed_val;

   function automatic logic [6:0] tap_lookup(input logic [3:0] sel);
      logic [3:0] k;
      k = (sel == 4'd8) ? 4'd8 : {1'b0, sel[2:0]};
      case (k)
         4'd0:    tap_lookup = 7'h60;
         4'd1:    tap_lookup = 7'h48;
         4'd2:    tap_lookup = 7'h78;
         4'd3:    tap_lookup = 7'h72;
         4'd4:    tap_lookup = 7'h6A;
         4'd5:    tap_lookup = 7'h69;
         4'd6:    tap_lookup = 7'h5C;
         4'd7:    tap_lookup = 7'h7E;
         default: tap_lookup = 7'h7B;
      endcase
   endfunction

   // Offset wraps mod 256; the i>=pre test keeps wrapped offsets out of the message.
   assign msg_ofs  = {1'b0, idx} - pre_len;
   assign in_msg   = ({1'b0, idx} >= pre_len) && (msg_ofs < 8'd61);
   assign cipher   = ptxt[6:0] ^ lfsr;
   assign tap_sel  = tap_lookup(MemRdData[3:0]);
   assign seed_val = (MemRdData[6:0] == 7'd0) ? 7'h01 : MemRdData[6:0];

   always_comb begin
      state_nxt = state;
      Ack       = 1'b0;
      MemAddr   = 8'd0;
      MemWrEn   = 1'b0;
      MemWrData = 8'd0;
      case (state)
         IDLE: begin
            if (!Start) state_nxt = LD_PRE;
         end
         LD_PRE: begin
            MemAddr   = 8'(CFG_BASE);
            state_nxt = Start ? IDLE : LD_TAP;
         end
         LD_TAP: begin
            MemAddr   = 8'(CFG_BASE + 1);
            state_nxt = Start ? IDLE : LD_SEED;
         end
         LD_SEED: begin
            MemAddr   = 8'(CFG_BASE + 2);
            state_nxt = Start ? IDLE : ENC_RD;
         end
         ENC_RD: begin
            MemAddr   = in_msg ? 8'(MSG_BASE) + msg_ofs : 8'(MSG_BASE);
            state_nxt = Start ? IDLE : ENC_WR;
         end
         ENC_WR: begin
            MemAddr   = 8'(OUT_BASE) + {1'b0, idx};
            MemWrData = {^cipher, cipher};
            MemWrEn   = !Start;
            if (Start)                          state_nxt = IDLE;
            else if (idx == 7'(PAD_LEN - 1))    state_nxt = DONE;
            else                                state_nxt = ENC_RD;
         end
         DONE: begin
            Ack = 1'b1;
            if (Start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         idx     <= 7'd0;
         lfsr    <= 7'd0;
         pre_len <= 8'd0;
         tap     <= 7'd0;
         ptxt    <= 8'd0;
      end else begin
         state <= state_nxt;
         case (state)
            LD_PRE:  pre_len <= MemRdData;
            LD_TAP:  tap     <= tap_sel;
            LD_SEED: begin
               lfsr <= seed_val;
               idx  <= 7'd0;
            end
            ENC_RD:  ptxt <= in_msg ? MemRdData : 8'h20;
            ENC_WR: begin
               lfsr <= {lfsr[5:0], ^(lfsr & tap)};
               idx  <= idx + 7'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Scoreboard bench for crypt_sequencer: a behavioural model queues the expected
// memory writes, a monitor pops and compares each write the DUT issues.
module tb_crypt_sequencer;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Start;
   logic       Ack;
   logic [7:0] MemAddr;
   logic [7:0] MemRdData;
   logic       MemWrEn;
   logic [7:0] MemWrData;

   logic [7:0] mem [256];
   logic [7:0] exp_out [64];
   logic [7:0] saved [64];
   logic [15:0] sb [$];
   int n_chk = 0;
   int n_fail = 0;
   int wr_count = 0;

   crypt_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .MemAddr(MemAddr), .MemRdData(MemRdData),
      .MemWrEn(MemWrEn), .MemWrData(MemWrData)
   );

   always #5 Clk = ~Clk;

   assign MemRdData = mem[MemAddr];

   always @(posedge Clk)
      if (MemWrEn) mem[MemAddr] <= MemWrData;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge Clk) begin
      #2;
      if (MemWrEn) begin
         wr_count++;
         if (sb.size() == 0) begin
            chk("unexpected_write_addr", int'(MemAddr), 999);
         end else begin
            logic [15:0] e;
            e = sb.pop_front();
            chk("write_addr", int'(MemAddr), int'(e[15:8]));
            chk("write_data", int'(MemWrData), int'(e[7:0]));
         end
      end
   end

   function automatic logic [6:0] tap_of(input logic [7:0] sel);
      int k;
      k = (sel % 16 == 8) ? 8 : sel % 8;
      case (k)
         0: return 7'h60;  1: return 7'h48;  2: return 7'h78;
         3: return 7'h72;  4: return 7'h6A;  5: return 7'h69;
         6: return 7'h5C;  7: return 7'h7E;  default: return 7'h7B;
      endcase
   endfunction

   // Reference: padded plaintext = pre spaces, the 61-byte message, then spaces.
   task automatic build_expected();
      int pre;
      logic [6:0] lfsr, tap, c;
      logic [7:0] p;
      pre  = int'(mem[61]);
      tap  = tap_of(mem[62]);
      lfsr = mem[63][6:0];
      if (lfsr == 7'd0) lfsr = 7'd1;
      for (int i = 0; i < 64; i++) begin
         p = (i >= pre && i - pre < 61) ? mem[i - pre] : 8'h20;
         c = p[6:0] ^ lfsr;
         exp_out[i] = {^c, c};
         sb.push_back({8'(64 + i), exp_out[i]});
         lfsr = {lfsr[5:0], ^(lfsr & tap)};
      end
   endtask

   task automatic load_msg(input string s);
      for (int i = 0; i < 61; i++) mem[i] = (i < s.len()) ? 8'(s[i]) : 8'h20;
   endtask

   task automatic set_cfg(input int pre, input int sel, input int seed);
      mem[61] = 8'(pre);
      mem[62] = 8'(sel);
      mem[63] = 8'(seed);
   endtask

   // stop_edge<0: full run. Otherwise Start (or Reset) is sampled high at that edge.
   task automatic run_job(input int stop_edge, input bit use_reset);
      build_expected();
      wr_count = 0;
      @(negedge Clk);
      Start = 1'b0;
      for (int e = 0; e <= 131; e++) begin
         @(posedge Clk);
         @(negedge Clk);
         #1;
         if (e == 130) chk("ack_before_E131", int'(Ack), 0);
         if (e == 131) chk("ack_after_E131", int'(Ack), 1);
         if (stop_edge >= 0 && e == stop_edge - 1) begin
            if (use_reset) Reset = 1'b1;
            else           Start = 1'b1;
         end
         if (stop_edge >= 0 && e == stop_edge) begin
            chk("abort_ack", int'(Ack), 0);
            chk("abort_wren", int'(MemWrEn), 0);
            chk("abort_addr", int'(MemAddr), 0);
            break;
         end
      end
      if (stop_edge >= 0) begin
         Reset = 1'b0;
         Start = 1'b1;
         repeat (6) @(negedge Clk);
         #1;
         chk("abort_ack_stays_low", int'(Ack), 0);
         chk("abort_writes_done", wr_count, (stop_edge - 4) / 2);
         chk("abort_pending", sb.size(), 64 - (stop_edge - 4) / 2);
         sb.delete();
      end else begin
         repeat (4) @(negedge Clk);
         #1;
         chk("ack_held", int'(Ack), 1);
         chk("write_count", wr_count, 64);
         chk("scoreboard_empty", sb.size(), 0);
         for (int i = 0; i < 64; i++)
            if (mem[64 + i] != exp_out[i]) chk("mem_result", int'(mem[64 + i]), int'(exp_out[i]));
         Start = 1'b1;
         @(negedge Clk);
         #1;
         chk("ack_drop", int'(Ack), 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      Reset = 1'b1;
      Start = 1'b1;
      repeat (3) @(negedge Clk);
      #1;
      chk("reset_ack", int'(Ack), 0);
      chk("reset_wren", int'(MemWrEn), 0);
      chk("reset_addr", int'(MemAddr), 0);
      chk("reset_wrdata", int'(MemWrData), 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      chk("idle_ack", int'(Ack), 0);

      load_msg("I love cryptography, sequencers and LFSR streams!");
      set_cfg(10, 5, 8'h01);
      run_job(-1, 1'b0);
      chk("core64", int'(mem[64]), 8'h21);
      chk("core65", int'(mem[65]), 8'hA3);
      for (int i = 0; i < 64; i++) saved[i] = mem[64 + i];

      set_cfg(10, 5, 8'h00);
      run_job(-1, 1'b0);
      for (int i = 0; i < 64; i++)
         if (mem[64 + i] != saved[i]) chk("seed0_equals_seed1", int'(mem[64 + i]), int'(saved[i]));

      set_cfg(10, 8'h0D, 8'h01);
      run_job(-1, 1'b0);
      for (int i = 0; i < 64; i++)
         if (mem[64 + i] != saved[i]) chk("sel0D_equals_sel5", int'(mem[64 + i]), int'(saved[i]));

      set_cfg(10, 8, 8'h2B);
      run_job(-1, 1'b0);
      set_cfg(10, 8'h0F, 8'h55);
      run_job(-1, 1'b0);

      load_msg("KEEP THIS MESSAGE SECRET FROM THE OTHER TEAMMATES");
      set_cfg(15, 3, 8'h47);
      run_job(-1, 1'b0);

      set_cfg(200, 6, 8'h80);
      run_job(-1, 1'b0);

      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 61; i++) mem[i] = 8'($urandom_range(32, 126));
         set_cfg($urandom_range(0, 70), $urandom_range(0, 255), $urandom_range(0, 255));
         run_job(-1, 1'b0);
      end

      set_cfg(12, 2, 8'h33);
      run_job(50, 1'b0);
      run_job(-1, 1'b0);

      set_cfg(7, 4, 8'h11);
      run_job(70, 1'b1);
      run_job(-1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
